wide_alu_sequencer: RTL and testbench
=====================================

# wide_alu_sequencer

Multi-cycle controller that performs 8·NBYTES-bit arithmetic and logic operations by driving the 8-bit ALU one byte per cycle, least-significant byte first, and chaining carry/borrow through ADDC/SUBC. It sits directly around the ALU. Upstream, it supplies operand bytes, function code and carry-in. Downstream, it consumes the ALU's byte result, carry-out and zero flag, assembles the wide result and reports wide carry and zero flags.

## Interface
- NBYTES, 4, number of 8-bit operand bytes (≥2).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  3  function code, shared ALU encoding (ADD_FN, ADDC_FN, SUB_FN, SUBC_FN, AND_FN, OR_FN, XOR_FN, MASK_FN).
- a, b  in  8·NBYTES  wide operands.
- cin  in  1  carry-in for byte 0 of ADDC_FN/SUBC_FN.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  8·NBYTES  assembled result.
- carry  out  1  final carry/borrow.
- zero  out  1  high when the whole result is zero.
- alu_in1, alu_in2  out  8  current operand bytes to the ALU.
- alu_opcode  out  3  function code to the ALU.
- alu_cin  out  1  carry-in to the ALU.
- alu_out  in  8  ALU byte result.
- alu_cout  in  1  ALU carry-out. For SUB/SUBC, 1 means borrow.
- alu_z  in  1  ALU zero flag for the current byte.

## Operation
- States: IDLE, RUN, DONE.
- On an IDLE edge with start=1:
  - latch a, b, op and cin into operand registers.
  - clear the byte index idx to 0.
  - clear the running zero accumulator to 1.
  - go to RUN.
- IDLE with start=0 stays in IDLE.
- RUN, combinational drive:
  - alu_in1 = latched a byte idx; alu_in2 = latched b byte idx.
  - At idx=0: alu_opcode = latched op; alu_cin = latched cin.
  - At idx>0: ADD_FN/ADDC_FN map to ADDC_FN and SUB_FN/SUBC_FN map to SUBC_FN; logical codes pass unchanged. alu_cin = internal carry register.
- RUN, each edge:
  - result byte idx ← alu_out.
  - carry register ← alu_cout.
  - zero accumulator ← accumulator & alu_z.
  - idx ← idx+1.
  - When idx = NBYTES−1, go to DONE instead of incrementing.
- DONE:
  - done=1 for exactly one cycle.
  - carry output = carry register; zero output = accumulator.
  - Next edge returns to IDLE.
- In IDLE, ALU drive outputs are 0 (opcode ADD_FN, cin 0).
- result, carry and zero hold their values from completion until the next accepted start. At that accepted start they are not cleared; bytes are overwritten as RUN proceeds.
- Logical ops: ALU cout is 0, so the final carry is 0.
- start asserted while busy=1 (RUN or DONE) is ignored and not queued.
- Operand inputs may change after the accepting edge without affecting the operation.

## Timing
- Reset (rst_n=0 at an edge), values from the next cycle:
  - state IDLE, idx 0.
  - busy 0, done 0.
  - result all zeros, carry 0, zero 0, internal carry 0.
  - ALU drive outputs 0.
- Latency:
  - start accepted at edge k.
  - RUN occupies cycles k+1 … k+NBYTES.
  - done=1 in cycle k+NBYTES+1; result valid in that cycle.
  - busy falls one cycle later.
- Throughput: one operation per NBYTES+2 cycles. The earliest next start is accepted at the edge ending the DONE cycle+1, i.e. the first IDLE cycle.
- Reset asserted mid-RUN or in DONE aborts the operation: no done pulse, all outputs take reset values.
- ALU interface is purely combinational within a cycle. The carry chain passes through the registered carry only, so there is no combinational loop.

## Test plan
All scenarios use NBYTES=4.
- ADD_FN, a=0x000000FF, b=0x00000001, start at edge k -> result 0x00000100, carry 0, zero 0, done high only in cycle k+5.
- ADD_FN, a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, carry 1, zero 1. ALU sees ADDC_FN with alu_cin=1 at idx 1–3.
- SUB_FN, a=0x00000000, b=0x00000001 -> result 0xFFFFFFFF, carry 1 (borrow), zero 0. Then SUB_FN 0x12345678−0x12345678 -> 0, carry 0, zero 1.
- ADDC_FN with cin=1, a=0x12345678, b=0 -> 0x12345679. SUBC_FN with cin=1, a=0x00010000, b=0 -> 0x0000FFFF, carry 0.
- XOR_FN 0xA5A5A5A5^0xA5A5A5A5 -> 0, zero 1, carry 0. MASK_FN 0xFFFFFFFF,0xFFFFFFFF -> 0x00000000, zero 1. opcode stays unchanged across all four bytes.
- start held high through RUN -> exactly one operation, one done pulse. rst_n=0 at idx=2 -> next cycle busy 0, done 0, result 0, and no done pulse ever follows.

Source files
------------

// File: rtl/wide_alu_sequencer.sv
// Byte-serial controller that runs an 8-bit ALU over NBYTES operand bytes, LSB first,
// chaining carry/borrow through a registered carry and assembling the wide result.
module wide_alu_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic [7:0]            alu_in1,
    output logic [7:0]            alu_in2,
    output logic [2:0]            alu_opcode,
    output logic                  alu_cin,
    input  logic [7:0]            alu_out,
    input  logic                  alu_cout,
    input  logic                  alu_z
);

    localparam logic [2:0] ADD_FN  = 3'd0;
    localparam logic [2:0] ADDC_FN = 3'd1;
    localparam logic [2:0] SUB_FN  = 3'd2;
    localparam logic [2:0] SUBC_FN = 3'd3;

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [8*NBYTES-1:0]  a_reg, b_reg, result_reg;
    logic [2:0]           op_reg;
    logic                 cin_reg;
    logic                 carry_reg;
    logic                 zacc_reg;

    logic [7:0]           a_bytes [NBYTES];
    logic [7:0]           b_bytes [NBYTES];
    logic [NBYTES-1:0]    byte_we;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign a_bytes[gi] = a_reg[gi*8 +: 8];
            assign b_bytes[gi] = b_reg[gi*8 +: 8];
            assign byte_we[gi] = (state_reg == RUN) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_opcode = ADD_FN;
        alu_cin    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    idx_next   = '0;
                end
            end
            RUN: begin
                alu_in1 = a_bytes[idx_reg];
                alu_in2 = b_bytes[idx_reg];
                if (idx_reg == '0) begin
                    alu_opcode = op_reg;
                    alu_cin    = cin_reg;
                end else begin
                    // Upper bytes always consume the carry/borrow of the byte below.
                    alu_cin = carry_reg;
                    case (op_reg)
                        ADD_FN, ADDC_FN: alu_opcode = ADDC_FN;
                        SUB_FN, SUBC_FN: alu_opcode = SUBC_FN;
                        default:         alu_opcode = op_reg;
                    endcase
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= ADD_FN;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            zacc_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == IDLE && start) begin
                a_reg    <= a;
                b_reg    <= b;
                op_reg   <= op;
                cin_reg  <= cin;
                zacc_reg <= 1'b1;
            end
            if (state_reg == RUN) begin
                carry_reg <= alu_cout;
                zacc_reg  <= zacc_reg & alu_z;
            end
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_we[i]) begin
                    result_reg[i*8 +: 8] <= alu_out;
                end
            end
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign carry  = carry_reg;
    assign zero   = zacc_reg;

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Drives the sequencer against a byte ALU model and compares each wide operation with
// whole-word arithmetic computed in the bench.
module tb_wide_alu_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    localparam logic [2:0] ADD_FN  = 3'd0;
    localparam logic [2:0] ADDC_FN = 3'd1;
    localparam logic [2:0] SUB_FN  = 3'd2;
    localparam logic [2:0] SUBC_FN = 3'd3;
    localparam logic [2:0] AND_FN  = 3'd4;
    localparam logic [2:0] OR_FN   = 3'd5;
    localparam logic [2:0] XOR_FN  = 3'd6;
    localparam logic [2:0] MASK_FN = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          cin;
    logic          busy, done;
    logic [W-1:0]  result;
    logic          carry, zero;
    logic [7:0]    alu_in1, alu_in2;
    logic [2:0]    alu_opcode;
    logic          alu_cin;
    logic [7:0]    alu_out;
    logic          alu_cout;
    logic          alu_z;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wide_alu_sequencer #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry      (carry),
        .zero       (zero),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_cin    (alu_cin),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .alu_z      (alu_z)
    );

    // 8-bit ALU the sequencer wraps; SUB/SUBC report borrow in cout.
    logic [8:0] alu_t9;
    always_comb begin
        alu_t9 = '0;
        case (alu_opcode)
            ADD_FN:  alu_t9 = {1'b0, alu_in1} + {1'b0, alu_in2};
            ADDC_FN: alu_t9 = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'd0, alu_cin};
            SUB_FN:  alu_t9 = {1'b0, alu_in1} - {1'b0, alu_in2};
            SUBC_FN: alu_t9 = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'd0, alu_cin};
            AND_FN:  alu_t9 = {1'b0, alu_in1 & alu_in2};
            OR_FN:   alu_t9 = {1'b0, alu_in1 | alu_in2};
            XOR_FN:  alu_t9 = {1'b0, alu_in1 ^ alu_in2};
            MASK_FN: alu_t9 = {1'b0, alu_in1 & ~alu_in2};
            default: alu_t9 = '0;
        endcase
        alu_out  = alu_t9[7:0];
        alu_cout = alu_t9[8];
        alu_z    = (alu_t9[7:0] == 8'd0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic is_arith(input logic [2:0] f);
        return (f == ADD_FN) || (f == ADDC_FN) || (f == SUB_FN) || (f == SUBC_FN);
    endfunction

    function automatic logic is_sub(input logic [2:0] f);
        return (f == SUB_FN) || (f == SUBC_FN);
    endfunction

    // Effective carry-in of the whole-word operation.
    function automatic logic eff_cin(input logic [2:0] f, input logic c);
        return ((f == ADDC_FN) || (f == SUBC_FN)) ? c : 1'b0;
    endfunction

    // Whole-word reference: result and final carry/borrow.
    function automatic logic [W:0] ref_word(input logic [2:0] f, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic c);
        logic [63:0] xs, ys, s;
        logic ce;
        xs = 64'(x);
        ys = 64'(y);
        ce = eff_cin(f, c);
        case (f)
            ADD_FN, ADDC_FN: begin
                s = xs + ys + 64'(ce);
                return {s[W], s[W-1:0]};
            end
            SUB_FN, SUBC_FN: begin
                s = xs - ys - 64'(ce);
                return {(xs < ys + 64'(ce)), s[W-1:0]};
            end
            AND_FN:  return {1'b0, x & y};
            OR_FN:   return {1'b0, x | y};
            XOR_FN:  return {1'b0, x ^ y};
            default: return {1'b0, x & ~y};
        endcase
    endfunction

    // Carry (or borrow) arriving at byte i, derived from the low i bytes of the operands.
    function automatic logic ref_byte_cin(input logic [2:0] f, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic c, input int i);
        logic [63:0] m, xl, yl, ce;
        if (i == 0) return c;
        if (!is_arith(f)) return 1'b0;
        m  = (64'd1 << (8 * i)) - 64'd1;
        xl = 64'(x) & m;
        yl = 64'(y) & m;
        ce = 64'(eff_cin(f, c));
        if (is_sub(f)) return (xl < yl + ce);
        return ((xl + yl + ce) >> (8 * i)) != 64'd0;
    endfunction

    function automatic logic [2:0] ref_opcode(input logic [2:0] f, input int i);
        if (i == 0) return f;
        if (f == ADD_FN || f == ADDC_FN) return ADDC_FN;
        if (f == SUB_FN || f == SUBC_FN) return SUBC_FN;
        return f;
    endfunction

    // Starts one operation from IDLE and checks every cycle through the first IDLE cycle after.
    task automatic run_op(input logic [2:0] x_op, input logic [W-1:0] x_a,
                          input logic [W-1:0] x_b, input logic x_c);
        logic [W:0] exp;
        exp   = ref_word(x_op, x_a, x_b, x_c);
        start = 1'b1;
        op    = x_op;
        a     = x_a;
        b     = x_b;
        cin   = x_c;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < NBYTES; i++) begin
            check_eq("run_busy", 64'(busy), 64'd1);
            check_eq("run_done", 64'(done), 64'd0);
            check_eq("alu_opcode", 64'(alu_opcode), 64'(ref_opcode(x_op, i)));
            check_eq("alu_cin", 64'(alu_cin), 64'(ref_byte_cin(x_op, x_a, x_b, x_c, i)));
            check_eq("alu_in1", 64'(alu_in1), 64'(x_a[i*8 +: 8]));
            check_eq("alu_in2", 64'(alu_in2), 64'(x_b[i*8 +: 8]));
            @(posedge clk); #1;
        end
        $display("op=%0d a=%08h b=%08h cin=%0d -> result=%08h carry=%0d zero=%0d (exp %08h %0d %0d)",
                 x_op, x_a, x_b, x_c, result, carry, zero, exp[W-1:0], exp[W],
                 (exp[W-1:0] == '0));
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("done_busy", 64'(busy), 64'd1);
        check_eq("result", 64'(result), 64'(exp[W-1:0]));
        check_eq("carry", 64'(carry), 64'(exp[W]));
        check_eq("zero", 64'(zero), 64'(exp[W-1:0] == '0));
        @(posedge clk); #1;
        check_eq("idle_done", 64'(done), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_result", 64'(result), 64'(exp[W-1:0]));
        check_eq("idle_opcode", 64'(alu_opcode), 64'(ADD_FN));
    endtask

    initial begin
        int          pulses;
        logic [2:0]  r_op;
        logic [W-1:0] r_a, r_b;

        rst_n = 1'b0;
        start = 1'b0;
        op    = ADD_FN;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_carry", 64'(carry), 64'd0);
        check_eq("rst_zero", 64'(zero), 64'd0);
        check_eq("rst_alu_in", 64'({alu_in1, alu_in2, alu_opcode, alu_cin}), 64'd0);

        // Idle with start low must stay idle.
        @(posedge clk); #1;
        check_eq("idle_hold", 64'(busy), 64'd0);

        run_op(ADD_FN,  32'h0000_00FF, 32'h0000_0001, 1'b0);
        run_op(ADD_FN,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(SUB_FN,  32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op(SUB_FN,  32'h1234_5678, 32'h1234_5678, 1'b0);
        run_op(ADDC_FN, 32'h1234_5678, 32'h0000_0000, 1'b1);
        run_op(SUBC_FN, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op(XOR_FN,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        run_op(MASK_FN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(ADD_FN,  32'h0000_0001, 32'h0000_0000, 1'b1);
        run_op(OR_FN,   32'h0000_0000, 32'h0000_0000, 1'b1);

        for (int t = 0; t < 30; t++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = W'($urandom);
            case ($urandom_range(0, 3))
                0:       r_b = r_a;
                1:       r_b = ~r_a;
                default: r_b = W'($urandom);
            endcase
            run_op(r_op, r_a, r_b, 1'($urandom));
        end

        // start held high through RUN and DONE: exactly one operation.
        start = 1'b1;
        op    = ADD_FN;
        a     = 32'h0000_0010;
        b     = 32'h0000_0020;
        cin   = 1'b0;
        @(posedge clk); #1;
        pulses = 0;
        for (int i = 0; i < NBYTES + 1; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("held_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        check_eq("held_pulses", 64'(pulses), 64'd1);
        check_eq("held_result", 64'(result), 64'h30);

        // Reset at idx=2 aborts the operation.
        start = 1'b1;
        op    = ADD_FN;
        a     = 32'h1111_1111;
        b     = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        check_eq("abort_flags", 64'({carry, zero}), 64'd0);
        check_eq("abort_alu_in", 64'({alu_in1, alu_in2, alu_opcode, alu_cin}), 64'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) pulses++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_done", 64'(pulses), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
